// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the data-side load/store controller.
// The size codes and fifo_if register indices must match the control path and the fifo_if block.
package mem_ctrl_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  localparam logic [31:0] DMEM_BASE_DEF = 32'h1000_0000;
  localparam logic [31:0] MMIO_BASE_DEF = 32'h2000_0000;

  localparam logic [1:0] FIFO_REG_DATA   = 2'd0;
  localparam logic [1:0] FIFO_REG_STATUS = 2'd1;
  localparam logic [1:0] FIFO_REG_CTRL   = 2'd2;
  localparam logic [1:0] FIFO_REG_LEVEL  = 2'd3;

  typedef enum logic {ST_IDLE, ST_RESP} state_t;
  typedef enum logic {TGT_DMEM, TGT_MMIO} target_t;

  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == MEM_SIZE_H) && off[0]) || ((size == MEM_SIZE_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_ctrl_lanes.sv
// Byte-lane steering for the data port: store byte enables and lane replication,
// plus load extraction with sign or zero extension. Purely combinational.
module mem_lanes
  import mem_ctrl_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = ld_word_i[{ld_off_i, 3'b000} +: 8];
  assign w_half = ld_off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_wdata_i;
    case (st_size_i)
      MEM_SIZE_B: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      MEM_SIZE_H: begin
        st_be_o    = st_off_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_o = {2{st_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data_o = ld_word_i;
    case (ld_size_i)
      MEM_SIZE_B: ld_data_o = ld_unsigned_i ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      MEM_SIZE_H: ld_data_o = ld_unsigned_i ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Data-side load/store controller: decodes requests to data RAM or the fifo_if window,
// completes stores in one cycle and stalls loads for one cycle while read data returns.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE = DMEM_BASE_DEF,
  parameter int unsigned DMEM_AW   = 10,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [1:0]         size_i,
  input  logic               unsigned_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  output logic               stall_o,
  output logic               rvalid_o,
  output logic [31:0]        rdata_o,
  output logic               fault_o,
  output logic [DMEM_AW-1:0] dmem_addr_o,
  output logic               dmem_we_o,
  output logic [3:0]         dmem_be_o,
  output logic [31:0]        dmem_wdata_o,
  input  logic [31:0]        dmem_rdata_i,
  output logic               fifo_sel_o,
  output logic               fifo_rd_o,
  output logic               fifo_wr_o,
  output logic [1:0]         fifo_addr_o,
  output logic [7:0]         fifo_wdata_o,
  input  logic [7:0]         fifo_rdata_i
);

  // 33-bit bounds so a window ending at 4 GiB cannot wrap.
  localparam logic [32:0] DMEM_END = {1'b0, DMEM_BASE} + (33'd4 << DMEM_AW);
  localparam logic [32:0] MMIO_END = {1'b0, MMIO_BASE} + 33'd16;

  state_t      r_state, w_nextState;
  logic [1:0]  r_off, r_size;
  logic        r_unsigned;
  target_t     r_target;
  logic        w_dmemHit, w_mmioHit, w_legal;
  logic [3:0]  w_be;
  logic [31:0] w_wdataRep, w_ldData;

  assign w_dmemHit = ({1'b0, addr_i} >= {1'b0, DMEM_BASE}) && ({1'b0, addr_i} < DMEM_END);
  assign w_mmioHit = ({1'b0, addr_i} >= {1'b0, MMIO_BASE}) && ({1'b0, addr_i} < MMIO_END);
  assign w_legal   = (size_i != 2'b11) && !isMisaligned(size_i, addr_i[1:0])
                     && (w_dmemHit || w_mmioHit);

  mem_lanes u_lanes (
    .st_size_i     (size_i),
    .st_off_i      (addr_i[1:0]),
    .st_wdata_i    (wdata_i),
    .st_be_o       (w_be),
    .st_wdata_o    (w_wdataRep),
    .ld_size_i     (r_size),
    .ld_off_i      (r_off),
    .ld_unsigned_i (r_unsigned),
    .ld_word_i     (dmem_rdata_i),
    .ld_data_o     (w_ldData)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state    <= ST_IDLE;
      r_off      <= 2'b00;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_target   <= TGT_DMEM;
    end else begin
      r_state <= w_nextState;
      if ((r_state == ST_IDLE) && (w_nextState == ST_RESP)) begin
        r_off      <= addr_i[1:0];
        r_size     <= size_i;
        r_unsigned <= unsigned_i;
        r_target   <= w_mmioHit ? TGT_MMIO : TGT_DMEM;
      end
    end
  end

  // Outputs are forced low while reset is held so an aborted load never shows rvalid.
  always_comb begin
    w_nextState  = r_state;
    stall_o      = 1'b0;
    rvalid_o     = 1'b0;
    rdata_o      = 32'd0;
    fault_o      = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_be_o    = 4'b0000;
    fifo_sel_o   = 1'b0;
    fifo_rd_o    = 1'b0;
    fifo_wr_o    = 1'b0;
    dmem_addr_o  = addr_i[DMEM_AW+1:2];
    dmem_wdata_o = w_wdataRep;
    fifo_addr_o  = addr_i[3:2];
    fifo_wdata_o = wdata_i[7:0];
    if (rstn_i) begin
      case (r_state)
        ST_IDLE: begin
          if (req_i) begin
            if (!w_legal) begin
              fault_o = 1'b1;
            end else if (we_i) begin
              if (w_dmemHit) begin
                dmem_we_o = 1'b1;
                dmem_be_o = w_be;
              end else begin
                fifo_sel_o = 1'b1;
                fifo_wr_o  = 1'b1;
              end
            end else begin
              stall_o     = 1'b1;
              fifo_sel_o  = w_mmioHit;
              fifo_rd_o   = w_mmioHit;
              w_nextState = ST_RESP;
            end
          end
        end
        ST_RESP: begin
          rvalid_o    = 1'b1;
          rdata_o     = (r_target == TGT_MMIO) ? {24'd0, fifo_rdata_i} : w_ldData;
          w_nextState = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a byte-level memory model predicts every output each cycle,
// while separate environment models of the RAM and fifo_if respond to the DUT's strobes.
module tb_mem_ctrl;

  localparam logic [31:0] DB = 32'h1000_0000;
  localparam logic [31:0] MB = 32'h2000_0000;

  typedef struct packed {
    logic        stall, rvalid, fault, dwe, sel, rd, wr, dmemHit;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [9:0]  daddr;
    logic [1:0]  faddr;
    logic [7:0]  fwdata;
    logic [31:0] rdata;
  } exp_t;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rstn_i, req_i, we_i, unsigned_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, rvalid_o, fault_o, dmem_we_o;
  logic [31:0] rdata_o, dmem_wdata_o, dmem_rdata_i;
  logic [9:0]  dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic        fifo_sel_o, fifo_rd_o, fifo_wr_o;
  logic [1:0]  fifo_addr_o;
  logic [7:0]  fifo_wdata_o, fifo_rdata_i;

  mem_ctrl dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .fault_o(fault_o),
    .dmem_addr_o(dmem_addr_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i),
    .fifo_sel_o(fifo_sel_o), .fifo_rd_o(fifo_rd_o), .fifo_wr_o(fifo_wr_o),
    .fifo_addr_o(fifo_addr_o), .fifo_wdata_o(fifo_wdata_o), .fifo_rdata_i(fifo_rdata_i)
  );

  // Environment: RAM and fifo_if registers that react to whatever the DUT drives.
  logic [31:0] envRam [0:1023];
  logic [7:0]  envFifo [0:3];
  logic [31:0] mergeWord;
  always @(posedge clk_i) begin
    if (dmem_we_o) begin
      mergeWord = envRam[dmem_addr_o];
      for (int i = 0; i < 4; i++)
        if (dmem_be_o[i]) mergeWord[8*i +: 8] = dmem_wdata_o[8*i +: 8];
      envRam[dmem_addr_o] <= mergeWord;
    end
    dmem_rdata_i <= envRam[dmem_addr_o];
    if (fifo_sel_o && fifo_wr_o) envFifo[fifo_addr_o] <= fifo_wdata_o;
    if (fifo_sel_o && fifo_rd_o) fifo_rdata_i <= envFifo[fifo_addr_o];
  end

  // Reference model: byte-addressed image of RAM and the fifo registers.
  logic [7:0] modelMem [0:4095];
  logic [7:0] modelFifo [0:3];
  int   nVec = 0;
  int   nMis = 0;
  exp_t expCur;
  bit   chkEn = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nVec++;
    if (act !== req) begin
      nMis++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t zeroExp();
    exp_t e;
    e = '0;
    return e;
  endfunction

  function automatic bit isLegal(input logic [1:0] size, input logic [31:0] addr);
    bit inRange, aligned;
    inRange = (addr >= DB && addr < DB + 32'd4096) || (addr >= MB && addr < MB + 32'd16);
    aligned = (size == 2'd0) || (size == 2'd1 && addr % 2 == 0) || (size == 2'd2 && addr % 4 == 0);
    return inRange && aligned && size != 2'd3;
  endfunction

  function automatic exp_t modelIssue(input logic we, input logic [1:0] size,
                                      input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int   n;
    bit   dm;
    e  = zeroExp();
    n  = 1 << size;
    dm = addr >= DB && addr < DB + 32'd4096;
    e.dmemHit = dm;
    e.daddr   = 10'((addr - DB) / 4);
    e.faddr   = 2'((addr - MB) / 4);
    if (!isLegal(size, addr)) begin
      e.fault = 1'b1;
    end else if (we && dm) begin
      e.dwe = 1'b1;
      e.be  = 4'(((1 << n) - 1) << (addr % 4));
      for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wdata[8*(i % n) +: 8];
    end else if (we) begin
      e.sel = 1'b1; e.wr = 1'b1; e.fwdata = wdata[7:0];
    end else begin
      e.stall = 1'b1;
      if (!dm) begin e.sel = 1'b1; e.rd = 1'b1; end
    end
    return e;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [1:0] size, input logic uns,
                                            input logic [31:0] addr);
    int          n;
    logic [31:0] v;
    if (addr >= MB) return {24'd0, modelFifo[(addr - MB) / 4]};
    n = 1 << size;
    v = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(modelMem[addr - DB + k]) << (8 * k));
    if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  // Per-cycle comparison against the model's expectation.
  always @(negedge clk_i) begin
    if (chkEn) begin
      check("stall_o",    32'(stall_o),    32'(expCur.stall));
      check("rvalid_o",   32'(rvalid_o),   32'(expCur.rvalid));
      check("fault_o",    32'(fault_o),    32'(expCur.fault));
      check("dmem_we_o",  32'(dmem_we_o),  32'(expCur.dwe));
      check("dmem_be_o",  32'(dmem_be_o),  32'(expCur.be));
      check("fifo_sel_o", 32'(fifo_sel_o), 32'(expCur.sel));
      check("fifo_rd_o",  32'(fifo_rd_o),  32'(expCur.rd));
      check("fifo_wr_o",  32'(fifo_wr_o),  32'(expCur.wr));
      check("rdata_o",    rdata_o,         expCur.rdata);
      if (expCur.dwe) check("dmem_wdata_o", dmem_wdata_o, expCur.wdata);
      if (expCur.dmemHit && (expCur.dwe || expCur.stall))
        check("dmem_addr_o", 32'(dmem_addr_o), 32'(expCur.daddr));
      if (expCur.sel) check("fifo_addr_o", 32'(fifo_addr_o), 32'(expCur.faddr));
      if (expCur.wr) check("fifo_wdata_o", 32'(fifo_wdata_o), 32'(expCur.fwdata));
    end
  end

  typedef struct packed {
    logic        stall, fault, sel, rd, wr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [9:0]  daddr;
    logic [1:0]  faddr;
    logic [7:0]  fwdata;
    logic [31:0] rdata;
  } obs_t;

  // Drives one request, samples the issue cycle (and the response cycle for loads).
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output obs_t obs);
    exp_t e;
    obs = '0;
    req_i = 1'b1; we_i = we; size_i = size; unsigned_i = uns; addr_i = addr; wdata_i = wdata;
    e = modelIssue(we, size, addr, wdata);
    expCur = e;
    @(negedge clk_i);
    obs.stall = stall_o; obs.fault = fault_o; obs.sel = fifo_sel_o; obs.rd = fifo_rd_o;
    obs.wr = fifo_wr_o; obs.be = dmem_be_o; obs.wdata = dmem_wdata_o; obs.daddr = dmem_addr_o;
    obs.faddr = fifo_addr_o; obs.fwdata = fifo_wdata_o;
    @(posedge clk_i); #1;
    if (!e.fault && we) begin
      if (e.dmemHit) for (int k = 0; k < (1 << size); k++) modelMem[addr - DB + k] = wdata[8*k +: 8];
      else modelFifo[(addr - MB) / 4] = wdata[7:0];
    end
    if (!e.fault && !we) begin
      expCur = zeroExp();
      expCur.rvalid = 1'b1;
      expCur.rdata  = modelLoad(size, uns, addr);
      @(negedge clk_i);
      obs.rdata = rdata_o;
      @(posedge clk_i); #1;
    end
    req_i  = 1'b0;
    expCur = zeroExp();
  endtask

  task automatic idleCycle();
    req_i  = 1'b0;
    expCur = zeroExp();
    @(negedge clk_i);
    @(posedge clk_i); #1;
  endtask

  obs_t o;

  initial begin
    for (int i = 0; i < 1024; i++) envRam[i] = 32'd0;
    for (int i = 0; i < 4096; i++) modelMem[i] = 8'd0;
    for (int i = 0; i < 4; i++) begin envFifo[i] = 8'd0; modelFifo[i] = 8'd0; end
    envFifo[1] = 8'h5A; modelFifo[1] = 8'h5A;
    rstn_i = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = 2'd0; unsigned_i = 1'b0;
    addr_i = 32'd0; wdata_i = 32'd0; fifo_rdata_i = 8'd0;
    expCur = zeroExp();
    chkEn  = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    idleCycle();

    applyStimulus(1'b1, 2'd2, 1'b0, 32'h1000_0004, 32'hDEAD_BEEF, o);
    check("SW be",    32'(o.be), 32'hF);
    check("SW daddr", 32'(o.daddr), 32'd1);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h1000_0004, 32'd0, o);
    check("LW stall", 32'(o.stall), 32'd1);
    check("LW rdata", o.rdata, 32'hDEAD_BEEF);

    applyStimulus(1'b1, 2'd0, 1'b0, 32'h1000_0003, 32'h0000_0080, o);
    check("SB be",    32'(o.be), 32'h8);
    check("SB wdata", o.wdata, 32'h8080_8080);
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h1000_0003, 32'd0, o);
    check("LB rdata", o.rdata, 32'hFFFF_FF80);
    applyStimulus(1'b0, 2'd0, 1'b1, 32'h1000_0003, 32'd0, o);
    check("LBU rdata", o.rdata, 32'h0000_0080);

    applyStimulus(1'b1, 2'd2, 1'b0, 32'h1000_0010, 32'h8001_1234, o);
    applyStimulus(1'b0, 2'd1, 1'b0, 32'h1000_0012, 32'd0, o);
    check("LH rdata", o.rdata, 32'hFFFF_8001);
    applyStimulus(1'b0, 2'd1, 1'b1, 32'h1000_0012, 32'd0, o);
    check("LHU rdata", o.rdata, 32'h0000_8001);
    applyStimulus(1'b1, 2'd1, 1'b0, 32'h1000_0016, 32'h1234_ABCD, o);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h1000_0014, 32'd0, o);
    check("SH+LW rdata", o.rdata, 32'hABCD_0000);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h1000_0FFC, 32'd0, o);
    idleCycle();

    applyStimulus(1'b1, 2'd2, 1'b0, 32'h2000_0000, 32'h0000_0041, o);
    check("MMIO SW wr",    32'({o.sel, o.wr}), 32'b11);
    check("MMIO SW faddr", 32'(o.faddr), 32'd0);
    check("MMIO SW data",  32'(o.fwdata), 32'h41);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h2000_0004, 32'd0, o);
    check("MMIO LW rd",    32'(o.rd), 32'd1);
    check("MMIO LW faddr", 32'(o.faddr), 32'd1);
    check("MMIO LW rdata", o.rdata, 32'h0000_005A);
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h2000_0000, 32'd0, o);
    check("MMIO LB rdata", o.rdata, 32'h0000_0041);

    applyStimulus(1'b0, 2'd2, 1'b0, 32'h1000_0002, 32'd0, o);
    check("LW misaligned fault", 32'(o.fault), 32'd1);
    applyStimulus(1'b1, 2'd1, 1'b0, 32'h1000_0001, 32'hFFFF, o);
    check("SH misaligned fault", 32'(o.fault), 32'd1);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h3000_0000, 32'd0, o);
    check("LW unmapped fault", 32'(o.fault), 32'd1);
    applyStimulus(1'b1, 2'd3, 1'b0, 32'h1000_0000, 32'd0, o);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h1000_1000, 32'd0, o);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h2000_0010, 32'd0, o);
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h0FFF_FFFF, 32'd0, o);
    idleCycle();

    // Load aborted by reset in its response cycle.
    req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; unsigned_i = 1'b0; addr_i = 32'h1000_0004;
    expCur = modelIssue(1'b0, 2'd2, 32'h1000_0004, 32'd0);
    @(negedge clk_i); #1;
    rstn_i = 1'b0; req_i = 1'b0; expCur = zeroExp();
    repeat (2) begin
      @(posedge clk_i);
      @(negedge clk_i);
      check("reset rvalid_o", 32'(rvalid_o), 32'd0);
    end
    @(posedge clk_i); #1 rstn_i = 1'b1;
    idleCycle();
    check("post-reset idle rvalid_o", 32'(rvalid_o), 32'd0);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h1000_0004, 32'd0, o);
    check("post-reset LW rdata", o.rdata, 32'hDEAD_BEEF);
    idleCycle();

    chkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
